// File: rtl/cphy_sym_word_aligner.sv
// C-PHY receive symbol aligner: preamble/sync detection and 7-symbol framing.
// Emits aligned 21-bit words with a strobe plus sync and error flags.
module cphy_sym_word_aligner #(
    parameter int MIN_PREAMBLE = 7
) (
    input  logic        SymClk,
    input  logic        RST,
    input  logic [2:0]  SymIn,
    input  logic        SymValid,
    output logic [20:0] WordData,
    output logic        WordValid,
    output logic        SyncDet,
    output logic        Locked,
    output logic        SyncErr,
    output logic        SymErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LOCK
    } state_t;

    localparam logic [7:0] MIN_PRE = 8'(MIN_PREAMBLE);

    state_t      state_q, state_d;
    logic [7:0]  pre_q, pre_d;
    logic [2:0]  sync_q, sync_d;
    logic [2:0]  sym_q, sym_d;
    // Only the six most recent symbols are needed; the seventh is SymIn.
    logic [17:0] hist_q, hist_d;

    logic [20:0] word_d;
    logic        wv_d;
    logic        sd_d;
    logic        lock_d;
    logic        se_d;
    logic        ye_d;

    logic        is3;
    logic        is4;

    assign is3 = (SymIn == 3'd3);
    assign is4 = (SymIn == 3'd4);

    // State and counter register.
    always_ff @(posedge SymClk or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            sync_q  <= '0;
            sym_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sync_q  <= sync_d;
            sym_q   <= sym_d;
            hist_q  <= hist_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sync_d  = sync_q;
        sym_d   = sym_q;
        hist_d  = hist_q;
        if (!SymValid) begin
            state_d = S_IDLE;
            pre_d   = '0;
            sync_d  = '0;
            sym_d   = '0;
            hist_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is3) begin
                        state_d = S_PRE;
                        pre_d   = 8'd1;
                    end
                end
                S_PRE: begin
                    unique case (1'b1)
                        is3: begin
                            if (pre_q != 8'hFF)
                                pre_d = pre_q + 8'd1;
                        end
                        is4: begin
                            pre_d = '0;
                            if (pre_q >= MIN_PRE) begin
                                state_d = S_SYNC;
                                sync_d  = 3'd1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            pre_d   = '0;
                        end
                    endcase
                end
                S_SYNC: begin
                    unique case (1'b1)
                        (is4 && sync_q < 3'd5): begin
                            sync_d = sync_q + 3'd1;
                        end
                        (is3 && sync_q == 3'd5): begin
                            state_d = S_LOCK;
                            sync_d  = '0;
                            sym_d   = '0;
                            hist_d  = '0;
                        end
                        (is3 && sync_q < 3'd5): begin
                            // A stray 3 restarts the preamble count.
                            state_d = S_PRE;
                            pre_d   = 8'd1;
                            sync_d  = '0;
                        end
                        default: begin
                            state_d = S_IDLE;
                            sync_d  = '0;
                        end
                    endcase
                end
                S_LOCK: begin
                    hist_d = {hist_q[14:0], SymIn};
                    sym_d  = (sym_q == 3'd6) ? 3'd0 : sym_q + 3'd1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        word_d = WordData;
        wv_d   = 1'b0;
        sd_d   = 1'b0;
        se_d   = 1'b0;
        ye_d   = 1'b0;
        lock_d = (state_d == S_LOCK);
        if (SymValid) begin
            unique case (state_q)
                S_SYNC: begin
                    if (is3 && sync_q == 3'd5)
                        sd_d = 1'b1;
                    else if (!(is4 && sync_q < 3'd5))
                        se_d = 1'b1;
                end
                S_LOCK: begin
                    if (sym_q == 3'd6) begin
                        word_d = {hist_q, SymIn};
                        wv_d   = 1'b1;
                    end
                    if (SymIn > 3'd4)
                        ye_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output register.
    always_ff @(posedge SymClk or negedge RST) begin
        if (!RST) begin
            WordData  <= '0;
            WordValid <= 1'b0;
            SyncDet   <= 1'b0;
            Locked    <= 1'b0;
            SyncErr   <= 1'b0;
            SymErr    <= 1'b0;
        end else begin
            WordData  <= word_d;
            WordValid <= wv_d;
            SyncDet   <= sd_d;
            Locked    <= lock_d;
            SyncErr   <= se_d;
            SymErr    <= ye_d;
        end
    end

endmodule

// File: doc/cphy_sym_word_aligner.md
Name: cphy_sym_word_aligner

Overview:
- Receiver stage that sits directly upstream of the word clock generator and the 7-symbol-to-16-bit de-mapper.
- Samples 3-bit HS symbols on SymClk, detects the C-PHY preamble and sync word (3,4,4,4,4,4,3), and then groups subsequent symbols into aligned 7-symbol words.
- Presents each word as a 21-bit register with a one-cycle strobe, plus sync and error flags for the lane controller.

Parameters:
- MIN_PREAMBLE, 7, minimum count of consecutive symbol-3 values required before the first sync symbol-4 is accepted (range 1..255).

Ports:
- SymClk  input  1  symbol clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- SymIn  input  3  received symbol value; legal values 0..4.
- SymValid  input  1  HS burst active; SymIn is sampled only when high.
- WordData  output  21  aligned word; first symbol of the word in [20:18], last in [2:0].
- WordValid  output  1  one-cycle strobe; WordData is new.
- SyncDet  output  1  one-cycle pulse when the sync word completes.
- Locked  output  1  high while in LOCKED state.
- SyncErr  output  1  one-cycle pulse on a malformed sync sequence.
- SymErr  output  1  one-cycle pulse on an illegal symbol (greater than 4) while LOCKED.

Behaviour:
- Reset (RST low, async): state IDLE; all counters 0; WordData=0; WordValid, SyncDet, Locked, SyncErr, SymErr = 0.
- All outputs are registered. Pulses last exactly one SymClk cycle.
- SymValid low at any edge, in any state: next state is IDLE, counters cleared, any partial word discarded, WordData held, no pulses.
- FSM, evaluated only at edges where SymValid=1:
  - IDLE:
    - SymIn=3 → PRE, pre_cnt=1.
    - Any other value → stay IDLE.
  - PRE:
    - SymIn=3 → pre_cnt+1, saturating at 255 (8-bit).
    - SymIn=4 and pre_cnt>=MIN_PREAMBLE → SYNC, sync_cnt=1.
    - SymIn=4 and pre_cnt<MIN_PREAMBLE → IDLE.
    - Any other value → IDLE. No error pulse from PRE.
  - SYNC:
    - SymIn=4 and sync_cnt<5 → sync_cnt+1.
    - SymIn=3 and sync_cnt=5 → LOCKED, SyncDet=1 on the next cycle, sym_cnt=0.
    - SymIn=3 and sync_cnt<5 → PRE, pre_cnt=1 (counts as a new preamble start), SyncErr=1.
    - SymIn=4 and sync_cnt=5, or any other value → IDLE, SyncErr=1.
  - LOCKED:
    - Every valid symbol is shifted into a 21-bit shift register, newest symbol at [2:0].
    - sym_cnt runs 0..6 and wraps 6→0.
    - At the edge sampling the symbol with sym_cnt=6, WordData is loaded with the shift register including that symbol, and WordValid=1 for the following cycle.
    - First word = the 7 symbols immediately after the sync word's final 3.
    - Illegal symbol (5..7): SymErr=1 next cycle. The symbol is still shifted and counted, and lock is kept.
    - LOCKED exits only via SymValid low or reset. Sync patterns in payload are not re-detected.
- Locked = 1 exactly while state is LOCKED, and is registered alongside the state.
- Latency: WordValid asserts 1 cycle after the 7th symbol of a word is sampled. Steady-state word rate is 1 per 7 SymClk cycles.
- Reset asserted mid-word: immediate return to the reset values above. After deassertion, a full preamble and sync sequence is required again.

Test Plan:
- Reset: RST low with random SymIn/SymValid → all outputs 0, Locked=0. Release RST with SymValid=0 → outputs remain 0.
- Nominal burst: SymValid=1; 7×3, then 4,4,4,4,4,3, then payload 0,1,2,3,4,0,1 → SyncDet pulses 1 cycle after the final 3. WordData=21'b000_001_010_011_100_000_001 with WordValid pulsing 1 cycle after the 7th payload symbol. Continue with 2,2,2,2,2,2,2 → second WordValid exactly 7 cycles after the first, WordData=21'b010_010_010_010_010_010_010.
- Short preamble (MIN_PREAMBLE=7): 5×3 then 4,4,4,4,4,3 → no SyncDet, no SyncErr, Locked stays 0.
- Malformed sync: 7×3, then 4,4,3 → SyncErr pulse, FSM back in PRE. Then 6×3 and 4,4,4,4,4,3 → SyncDet (pre_cnt=7).
- Illegal symbol and burst end: locked, payload 1,1,7,1,1,1,1 → SymErr pulses after the 7; WordValid still fires with [14:12]=3'b111. Then drop SymValid after 3 symbols of the next word → Locked=0 next cycle, no WordValid, WordData unchanged.
- Async reset mid-word: assert RST low between SymClk edges while locked at sym_cnt=3 → Locked and WordData go 0 immediately. After release, payload without a new sync → no WordValid.
